// File: rtl/horner_sequencer_if.sv
// Bundle between the Horner sequencer and its surroundings: start/operand inputs,
// coefficient stream, shared-ALU operands/result and the result port.
interface horner_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEG_W = 2
);
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [DEG_W-1:0] deg_in;

    logic             coef_valid;
    logic             coef_ready;
    logic [WIDTH-1:0] coef_data;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_op;
    logic [WIDTH-1:0] alu_result;

    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;

    // The sequencer side.
    modport slave (
        input  start, x_in, deg_in,
        input  coef_valid, coef_data,
        output coef_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result,
        output busy, result_valid, result
    );

    // The side that issues work, streams coefficients and owns the ALU.
    modport master (
        output start, x_in, deg_in,
        output coef_valid, coef_data,
        input  coef_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result,
        input  busy, result_valid, result
    );
endinterface

// File: rtl/horner_sequencer.sv
// Horner-rule polynomial evaluator driving a shared external add/multiply ALU.
// Coefficients arrive highest order first; arithmetic wraps mod 2^WIDTH.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | waiting for start; x and degree latched when it arrives
//  FIRST     | waiting for the leading coefficient, loaded straight into acc
//  MUL       | acc <= acc * x on the ALU
//  WAIT_COEF | waiting for the next coefficient
//  ADD       | acc <= acc + coef on the ALU, one fewer coefficient to go
//  DONE      | result register holds the final value, one-cycle valid pulse
module horner_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEG_W = 2
) (
    input logic               clk,
    input logic               reset,
    horner_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIRST     = 3'd1,
        MUL       = 3'd2,
        WAIT_COEF = 3'd3,
        ADD       = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] coef_q, coef_d;
    logic [DEG_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             coef_ready;
    logic             alu_op;
    logic [WIDTH-1:0] alu_b;
    logic             busy;
    logic             result_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            coef_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // The result register is loaded on the transition into DONE with the same
    // value acc receives, so result is already valid while in DONE.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        x_d          = x_q;
        coef_d       = coef_q;
        rem_d        = rem_q;
        result_d     = result_q;
        coef_ready   = 1'b0;
        alu_op       = 1'b0;
        alu_b        = '0;
        busy         = (state_q != IDLE);
        result_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x_in;
                    rem_d   = bus.deg_in;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                coef_ready = 1'b1;
                if (bus.coef_valid) begin
                    acc_d = bus.coef_data;
                    if (rem_q == '0) begin
                        result_d = bus.coef_data;
                        state_d  = DONE;
                    end else begin
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                alu_op  = 1'b1;
                alu_b   = x_q;
                acc_d   = bus.alu_result;
                state_d = WAIT_COEF;
            end
            WAIT_COEF: begin
                coef_ready = 1'b1;
                if (bus.coef_valid) begin
                    coef_d  = bus.coef_data;
                    state_d = ADD;
                end
            end
            ADD: begin
                alu_b = coef_q;
                acc_d = bus.alu_result;
                rem_d = rem_q - DEG_W'(1);
                if (rem_q == DEG_W'(1)) begin
                    result_d = bus.alu_result;
                    state_d  = DONE;
                end else begin
                    state_d  = MUL;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.coef_ready   = coef_ready;
    assign bus.alu_a        = acc_q;
    assign bus.alu_b        = alu_b;
    assign bus.alu_op       = alu_op;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.result       = result_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Bench for horner_sequencer: directed vector table, reset/ignored-start sequences,
// and randomized runs checked against a power-sum polynomial model.
module tb_horner_sequencer;
    localparam int W = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    horner_sequencer_if #(.WIDTH(W), .DEG_W(D)) bus();
    horner_sequencer #(.WIDTH(W), .DEG_W(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Shared ALU as seen by the sequencer: combinational, truncated.
    assign bus.alu_result = bus.alu_op ? W'(bus.alu_a * bus.alu_b) : W'(bus.alu_a + bus.alu_b);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int              deg;
        logic [W-1:0]    x;
        logic [3:0][7:0] c;
        int              gap;
        int              opt;
        int              exp_res;
        int              exp_lat;
    } vec_t;

    function automatic vec_t mk(int deg, int x, int c0, int c1, int c2, int c3,
                                int gap, int opt, int res, int lat);
        vec_t v;
        v.deg = deg; v.x = W'(x);
        v.c[0] = 8'(c0); v.c[1] = 8'(c1); v.c[2] = 8'(c2); v.c[3] = 8'(c3);
        v.gap = gap; v.opt = opt; v.exp_res = res; v.exp_lat = lat;
        return v;
    endfunction

    // y = sum c[i] * x^(deg-i), everything mod 256.
    function automatic int ref_poly(int deg, logic [W-1:0] x, logic [3:0][7:0] c);
        int sum = 0;
        for (int i = 0; i <= deg; i++) begin
            int p = 1;
            for (int k = 0; k < deg - i; k++) p = (p * int'(x)) & 255;
            sum = (sum + int'(c[i]) * p) & 255;
        end
        return sum;
    endfunction

    // Called at a negedge; start is driven for that cycle. opt 1 pulses start in the
    // first MUL cycle, opt 2 pulses start in DONE. Returns at the IDLE cycle after DONE.
    task automatic run(input int deg, input logic [W-1:0] x, input logic [3:0][7:0] c,
                       input int gap, input int opt, input bit rnd_valid,
                       output int res, output int lat, output int pulses,
                       output int readys, output int muls, output int busy_err);
        int  idx = 0;
        int  gcnt = 0;
        bit  seen = 0;
        bit  injected = 0;
        res = -1; lat = -1; pulses = 0; readys = 0; muls = 0; busy_err = 0;
        bus.start      = 1'b1;
        bus.x_in       = x;
        bus.deg_in     = D'(deg);
        bus.coef_valid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.x_in   = W'($urandom);
            bus.deg_in = D'($urandom);
            if (bus.result_valid) begin
                pulses++;
                if (!seen) begin seen = 1; lat = cyc; res = int'(bus.result); end
            end
            if ((!seen && !bus.busy) || (seen && cyc > lat && bus.busy)) busy_err++;
            if (seen && cyc > lat) break;
            if (bus.coef_ready) readys++;
            if (bus.alu_op) muls++;
            if (opt == 1 && bus.alu_op && !injected) begin bus.start = 1'b1; injected = 1; end
            if (opt == 2 && bus.result_valid) bus.start = 1'b1;
            if (rnd_valid) bus.coef_valid = 1'($urandom_range(0, 1));
            else if (bus.coef_ready && gcnt < gap) begin bus.coef_valid = 1'b0; gcnt++; end
            else bus.coef_valid = 1'b1;
            bus.coef_data = (idx <= deg) ? c[idx] : W'($urandom);
            if (bus.coef_valid && bus.coef_ready) begin idx++; gcnt = 0; end
        end
        bus.start      = 1'b0;
        bus.coef_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int res, lat, pulses, readys, muls, berr;
        bit found;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.x_in       = '0;
        bus.deg_in     = '0;
        bus.coef_valid = 1'b0;
        bus.coef_data  = '0;

        vecs[0] = mk(2, 8'h03, 2, 3, 4, 0, 0, 0, 8'h1F, 8);
        vecs[1] = mk(0, 8'h55, 7, 0, 0, 0, 0, 0, 8'h07, 2);
        vecs[2] = mk(3, 8'h10, 1, 0, 0, 0, 0, 0, 8'h00, 11);
        vecs[3] = mk(1, 8'hFF, 8'hFF, 2, 0, 0, 0, 0, 8'h03, 5);
        vecs[4] = mk(2, 8'h03, 2, 3, 4, 0, 2, 0, 8'h1F, 14);
        vecs[5] = mk(2, 8'h03, 2, 3, 4, 0, 0, 1, 8'h1F, 8);
        vecs[6] = mk(1, 8'h02, 5, 1, 0, 0, 0, 2, 8'h0B, 5);
        vecs[7] = mk(3, 8'h02, 1, 2, 3, 4, 0, 0, 8'h1A, 11);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_ready", int'(bus.coef_ready), 0);
        chk("rst_rv",    int'(bus.result_valid), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_alu_op", int'(bus.alu_op), 0);
        chk("rst_alu_a", int'(bus.alu_a), 0);
        chk("rst_alu_b", int'(bus.alu_b), 0);

        foreach (vecs[i]) begin
            run(vecs[i].deg, vecs[i].x, vecs[i].c, vecs[i].gap, vecs[i].opt, 1'b0,
                res, lat, pulses, readys, muls, berr);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_pulses", i), pulses, 1);
            chk($sformatf("vec%0d_ready_cycles", i), readys, (vecs[i].deg + 1) * (vecs[i].gap + 1));
            chk($sformatf("vec%0d_mul_cycles", i), muls, vecs[i].deg);
            chk($sformatf("vec%0d_busy", i), berr, 0);
        end

        // Reset while waiting for the second coefficient of a degree-3 run.
        bus.start = 1'b1; bus.x_in = 8'h05; bus.deg_in = 2'd3;
        bus.coef_valid = 1'b1; bus.coef_data = 8'h09;
        found = 0;
        begin
            bit seen_mul = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.alu_op) seen_mul = 1;
                else if (seen_mul && bus.coef_ready) begin found = 1; break; end
            end
        end
        chk("reach_wait_coef", int'(found), 1);
        bus.coef_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_result", int'(bus.result), 0);
        chk("mid_rst_rv", int'(bus.result_valid), 0);
        chk("mid_rst_ready", int'(bus.coef_ready), 0);
        @(negedge clk);
        chk("mid_rst_no_rv", int'(bus.result_valid), 0);
        run(1, 8'h02, {8'h00, 8'h00, 8'h01, 8'h05}, 0, 0, 1'b0, res, lat, pulses, readys, muls, berr);
        chk("post_rst_result", res, 8'h0B);
        chk("post_rst_latency", lat, 5);

        // Randomized runs with random coef_valid against the power-sum model.
        for (int r = 0; r < 30; r++) begin
            int              deg = $urandom_range(0, 3);
            logic [W-1:0]    x = W'($urandom);
            logic [3:0][7:0] c = 32'($urandom);
            run(deg, x, c, 0, 0, 1'b1, res, lat, pulses, readys, muls, berr);
            chk($sformatf("rnd%0d_result", r), res, ref_poly(deg, x, c));
            chk($sformatf("rnd%0d_latency", r), lat, 3 * deg + 2 + (readys - (deg + 1)));
            chk($sformatf("rnd%0d_pulses", r), pulses, 1);
            chk($sformatf("rnd%0d_busy", r), berr, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
